keypad_scan_ctrl: RTL
=====================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_CYC, default 1000, giving the row settle/sample period in clk cycles (20 us at 50 MHz).
REQ-002 SHALL have parameter DEB_CYC, default 250000, giving the stable-time threshold in clk cycles for press and release (5 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port col_n, input, 4 bits: matrix column lines, active-low, asynchronous to clk.
REQ-006 SHALL have port row_n, output, 4 bits: matrix row drive, active-low.
REQ-007 SHALL have port key_code, output, 4 bits: last accepted key, equal to row_index*4 + col_index.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse per accepted press.
REQ-009 SHALL have port key_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 SHALL pass col_n through a 2-flop synchronizer (col_s) before any use; all decisions use col_s only.
REQ-011 SHALL implement FSM states IDLE, SCAN, DEBOUNCE, REPORT, RELEASE.
REQ-012 IDLE: row_n=4'b0000 and counters cleared; col_s != 4'hF -> SCAN with row index 0.
REQ-013 SCAN: row_n has only bit idx low; hold each row for SCAN_CYC cycles and sample col_s on the last cycle.
REQ-014 SCAN sample with any col_s bit low: latch idx and the lowest-numbered low column, then go to DEBOUNCE.
REQ-015 SCAN sample with no bit low: idx+1; after a miss on idx 3, go to IDLE (no wrap within one scan).
REQ-016 DEBOUNCE: hold the latched row and count consecutive cycles with the latched column low.
REQ-017 DEBOUNCE exit: the latched column goes high -> IDLE with no pulse; count reaches DEB_CYC-1 -> REPORT.
REQ-018 REPORT: lasts exactly 1 cycle; key_valid=1; key_code is loaded on entry; then go to RELEASE.
REQ-019 RELEASE: row_n=4'b0000; count consecutive cycles with col_s==4'hF; any low bit zeroes the count; count reaching DEB_CYC-1 -> IDLE.
REQ-020 A second key pressed while the first is held SHALL NOT generate a pulse; exactly one key_valid per press/release cycle.
REQ-021 key_code SHALL hold its value until the next REPORT; key_valid SHALL be 0 outside REPORT.
REQ-022 Counters SHALL be sized $clog2(max(SCAN_CYC,DEB_CYC)) bits, SHALL never wrap, and SHALL clear on every state change.
REQ-023 Latency: from the synchronized press being stable, key_valid follows ≤ 4*SCAN_CYC + DEB_CYC + 3 cycles.

Reset
REQ-024 rst SHALL force state=IDLE, row_n=4'b0000, key_code=4'h0, key_valid=0, key_busy=0, counters=0, idx=0, and both synchronizer stages to 4'hF.
REQ-025 rst asserted mid-DEBOUNCE or mid-RELEASE SHALL abort with no key_valid pulse; a key still held after reset is rescanned from IDLE.

Structure
REQ-026 The shared package SHALL hold the state encoding, KP_ROWS=4, KP_COLS=4, and the key-code width constant.
REQ-027 The column synchronizer SHALL be the sole sub-module, named col_sync (4-bit, 2-stage, reset value 4'hF).

Verification (SCAN_CYC=4, DEB_CYC=16)
REQ-028 Press row 2 / col 1 held for 100 cycles -> exactly one key_valid pulse with key_code=4'h9; row_n=4'b1011 during DEBOUNCE.
REQ-029 Bounce: col toggles low/high every 3 cycles for 40 cycles, then stays low -> no pulse during bounce, then one pulse after 16 stable cycles.
REQ-030 Simultaneous row 0 col 3 and row 0 col 0 -> key_code=4'h0 (lowest column wins); row 1 col 2 plus row 3 col 0 -> key_code=4'h6 (first scanned row wins).
REQ-031 Hold key 4'h5, release for 10 cycles, re-press, hold 100 cycles, release -> only one pulse, because RELEASE needs 16 consecutive high cycles.
REQ-032 rst pulsed 1 cycle during DEBOUNCE of key 4'hF -> all outputs at reset values the next cycle, no pulse from the aborted press, and one pulse with key_code=4'hF after rescan.
REQ-033 Press shorter than 16 cycles (e.g. 8) -> no key_valid, and return to IDLE with key_busy=0.

Source files
------------

// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared constants, FSM encoding and column-priority helper for the 4x4 keypad scanner.
package keypad_scan_ctrl_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 4;
  localparam int KP_CODE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_REPORT   = 3'd3,
    ST_RELEASE  = 3'd4
  } kp_state_e;

  // Index of the lowest-numbered active-low column; 0 when none is low.
  function automatic logic [1:0] lowest_low(input logic [KP_COLS-1:0] col);
    lowest_low = 2'd0;
    for (int i = KP_COLS-1; i >= 0; i--)
      if (!col[i]) lowest_low = 2'(i);
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_col_sync.sv
// Two-flop synchronizer for the asynchronous column lines; resets to "no key" (all high).
module col_sync
  import keypad_scan_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [KP_COLS-1:0] d_i,
  output logic [KP_COLS-1:0] q_o
);

  logic [KP_COLS-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: row scan, press debounce, single-pulse report, release debounce.
module keypad_scan_ctrl
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int SCAN_CYC = 1000,
  parameter int DEB_CYC  = 250000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KP_COLS-1:0]   col_n,
  output logic [KP_ROWS-1:0]   row_n,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 key_valid,
  output logic                 key_busy
);

  localparam int CNT_MAX = (SCAN_CYC > DEB_CYC) ? SCAN_CYC : DEB_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);

  kp_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            col_q, col_d;
  logic [KP_CODE_W-1:0]  code_q, code_d;
  logic [KP_COLS-1:0]    col_s;

  col_sync u_col_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (col_n),
    .q_o   (col_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      col_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    col_d     = col_q;
    code_d    = code_q;
    row_n     = '0;
    key_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (col_s != '1) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        row_n = ~(4'b0001 << idx_q);
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (col_s != '1) begin
            col_d   = lowest_low(col_s);
            state_d = ST_DEBOUNCE;
          end else if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        // idx_q stays frozen here and doubles as the latched row
        row_n = ~(4'b0001 << idx_q);
        if (col_s[col_q]) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          code_d  = {idx_q, col_q};
          state_d = ST_REPORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPORT: begin
        key_valid = 1'b1;
        cnt_d     = '0;
        state_d   = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (col_s != '1) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign key_code = code_q;
  assign key_busy = (state_q != ST_IDLE);

endmodule
